// File: rtl/ex_stage.sv
// ---------------------------------------------------------------------------
// ex_stage -- execute stage of the 5-stage pipeline
//
// Purpose:
//   Resolves ALU operands through the forwarding muxes and runs single-cycle
//   ALU operations. MUL goes through an iterative shift-add multiplier that
//   stalls the front end. This block owns the EX/MEM pipeline register.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   id_ex_*                 instruction fields from the ID/EX register
//   forward_a / forward_b   operand selects: 00 regfile, 10 EX/MEM,
//                           01 MEM/WB, 11 regfile
//   ex_mem_fwd_data         EX/MEM result, used as a forwarding source
//   mem_wb_fwd_data         MEM/WB writeback value, used as a forwarding source
//   flush                   squashes the EX instruction (also aborts a MUL)
//   ex_stall                holds PC, IF/ID and ID/EX while a MUL runs
//   ex_mem_*                registered EX/MEM pipeline outputs
// ---------------------------------------------------------------------------
module ex_stage #(
   parameter  int XLEN    = 32,
   localparam int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_ex_valid,
   input  logic [3:0]      id_ex_alu_op,
   input  logic            id_ex_alu_src,
   input  logic [XLEN-1:0] id_ex_imm,
   input  logic [XLEN-1:0] id_ex_rs1_data,
   input  logic [XLEN-1:0] id_ex_rs2_data,
   input  logic [4:0]      id_ex_rd,
   input  logic            id_ex_reg_write,
   input  logic            id_ex_mem_read,
   input  logic            id_ex_mem_write,
   input  logic [1:0]      forward_a,
   input  logic [1:0]      forward_b,
   input  logic [XLEN-1:0] ex_mem_fwd_data,
   input  logic [XLEN-1:0] mem_wb_fwd_data,
   input  logic            flush,
   output logic            ex_stall,
   output logic            ex_mem_valid,
   output logic [XLEN-1:0] ex_mem_alu_result,
   output logic [XLEN-1:0] ex_mem_store_data,
   output logic [4:0]      ex_mem_rd,
   output logic            ex_mem_reg_write,
   output logic            ex_mem_mem_read,
   output logic            ex_mem_mem_write
);

   typedef enum logic {ST_IDLE, ST_MUL_BUSY} state_t;

   localparam logic [3:0] OP_ADD   = 4'd0;
   localparam logic [3:0] OP_SUB   = 4'd1;
   localparam logic [3:0] OP_AND   = 4'd2;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_XOR   = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SRL   = 4'd6;
   localparam logic [3:0] OP_SRA   = 4'd7;
   localparam logic [3:0] OP_SLT   = 4'd8;
   localparam logic [3:0] OP_SLTU  = 4'd9;
   localparam logic [3:0] OP_MUL   = 4'd10;
   localparam logic [3:0] OP_PASSB = 4'd11;

   state_t             r_state;
   logic [XLEN-1:0]    r_mcand;
   logic [XLEN-1:0]    r_mplier;
   logic [XLEN-1:0]    r_product;
   logic [SHAMT_W-1:0] r_count;
   logic [4:0]         r_mul_rd;
   logic               r_mul_reg_write;

   logic [XLEN-1:0]    w_fwd_a;
   logic [XLEN-1:0]    w_fwd_b;
   logic [XLEN-1:0]    w_op_b;
   logic [XLEN-1:0]    w_alu_result;
   logic [XLEN-1:0]    w_product_next;
   logic [SHAMT_W-1:0] w_shamt;
   logic               w_busy;
   logic               w_is_mul;
   logic               w_accept;
   logic               w_mul_last;

   // Forwarding muxes; select 11 falls back to the register file.
   // NOTE: every always_comb output gets a default assignment first so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      w_fwd_a = id_ex_rs1_data;
      w_fwd_b = id_ex_rs2_data;
      case (forward_a)
         2'b10:   w_fwd_a = ex_mem_fwd_data;
         2'b01:   w_fwd_a = mem_wb_fwd_data;
         default: w_fwd_a = id_ex_rs1_data;
      endcase
      case (forward_b)
         2'b10:   w_fwd_b = ex_mem_fwd_data;
         2'b01:   w_fwd_b = mem_wb_fwd_data;
         default: w_fwd_b = id_ex_rs2_data;
      endcase
   end

   assign w_op_b  = id_ex_alu_src ? id_ex_imm : w_fwd_b;
   assign w_shamt = w_op_b[SHAMT_W-1:0];

   // Single-cycle ALU. MUL never completes through this path, so it and the
   // unused codes produce 0 here.
   always_comb begin
      w_alu_result = '0;
      case (id_ex_alu_op)
         OP_ADD:   w_alu_result = w_fwd_a + w_op_b;
         OP_SUB:   w_alu_result = w_fwd_a - w_op_b;
         OP_AND:   w_alu_result = w_fwd_a & w_op_b;
         OP_OR:    w_alu_result = w_fwd_a | w_op_b;
         OP_XOR:   w_alu_result = w_fwd_a ^ w_op_b;
         OP_SLL:   w_alu_result = w_fwd_a << w_shamt;
         OP_SRL:   w_alu_result = w_fwd_a >> w_shamt;
         OP_SRA:   w_alu_result = $unsigned($signed(w_fwd_a) >>> w_shamt);
         OP_SLT:   w_alu_result = {{(XLEN-1){1'b0}}, $signed(w_fwd_a) < $signed(w_op_b)};
         OP_SLTU:  w_alu_result = {{(XLEN-1){1'b0}}, w_fwd_a < w_op_b};
         OP_PASSB: w_alu_result = w_op_b;
         default:  w_alu_result = '0;
      endcase
   end

   assign w_busy         = (r_state == ST_MUL_BUSY);
   assign w_is_mul       = (id_ex_alu_op == OP_MUL);
   assign w_accept       = !w_busy && id_ex_valid && w_is_mul && !flush;
   assign w_mul_last     = w_busy && (r_count == SHAMT_W'(XLEN - 1));
   // Product including the current iteration; on the last iteration this is
   // the value written to EX/MEM.
   assign w_product_next = r_product + (r_mplier[0] ? r_mcand : '0);

   // Stall covers the accept cycle plus all busy cycles but the last, so the
   // front end is released on the edge that writes the product.
   assign ex_stall = w_accept || (w_busy && !flush && !w_mul_last);

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state           <= ST_IDLE;
         r_mcand           <= '0;
         r_mplier          <= '0;
         r_product         <= '0;
         r_count           <= '0;
         r_mul_rd          <= '0;
         r_mul_reg_write   <= 1'b0;
         ex_mem_valid      <= 1'b0;
         ex_mem_alu_result <= '0;
         ex_mem_store_data <= '0;
         ex_mem_rd         <= '0;
         ex_mem_reg_write  <= 1'b0;
         ex_mem_mem_read   <= 1'b0;
         ex_mem_mem_write  <= 1'b0;
      end else begin
         // Bubble by default: kill the control bits, hold the data fields.
         ex_mem_valid     <= 1'b0;
         ex_mem_reg_write <= 1'b0;
         ex_mem_mem_read  <= 1'b0;
         ex_mem_mem_write <= 1'b0;

         if (w_busy) begin
            if (flush) begin
               r_state <= ST_IDLE;
            end else begin
               r_product <= w_product_next;
               r_mcand   <= r_mcand << 1;
               r_mplier  <= r_mplier >> 1;
               r_count   <= r_count + SHAMT_W'(1);
               if (w_mul_last) begin
                  r_state           <= ST_IDLE;
                  ex_mem_valid      <= 1'b1;
                  ex_mem_alu_result <= w_product_next;
                  ex_mem_rd         <= r_mul_rd;
                  ex_mem_reg_write  <= r_mul_reg_write;
               end
            end
         end else if (w_accept) begin
            // Operands are captured here; forwarding sources are not looked
            // at again for this MUL.
            r_state         <= ST_MUL_BUSY;
            r_mcand         <= w_fwd_a;
            r_mplier        <= w_op_b;
            r_product       <= '0;
            r_count         <= '0;
            r_mul_rd        <= id_ex_rd;
            r_mul_reg_write <= id_ex_reg_write;
         end else if (!flush && !w_is_mul) begin
            ex_mem_valid      <= id_ex_valid;
            ex_mem_alu_result <= w_alu_result;
            ex_mem_store_data <= w_fwd_b;
            ex_mem_rd         <= id_ex_rd;
            ex_mem_reg_write  <= id_ex_reg_write;
            ex_mem_mem_read   <= id_ex_mem_read;
            ex_mem_mem_write  <= id_ex_mem_write;
         end
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_stage -- self-checking bench for ex_stage
//
// A behavioural model (plain arithmetic, a remaining-cycle count for MUL)
// predicts ex_stall and the EX/MEM register each cycle; one compare process
// checks the DUT against it on every falling edge. Directed sequences pin
// the model with hand-computed literals, then randomized traffic follows.
// ---------------------------------------------------------------------------
module tb_ex_stage;
   localparam int XLEN = 32;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            id_ex_valid;
   logic [3:0]      id_ex_alu_op;
   logic            id_ex_alu_src;
   logic [XLEN-1:0] id_ex_imm;
   logic [XLEN-1:0] id_ex_rs1_data;
   logic [XLEN-1:0] id_ex_rs2_data;
   logic [4:0]      id_ex_rd;
   logic            id_ex_reg_write;
   logic            id_ex_mem_read;
   logic            id_ex_mem_write;
   logic [1:0]      forward_a;
   logic [1:0]      forward_b;
   logic [XLEN-1:0] ex_mem_fwd_data;
   logic [XLEN-1:0] mem_wb_fwd_data;
   logic            flush;
   logic            ex_stall;
   logic            ex_mem_valid;
   logic [XLEN-1:0] ex_mem_alu_result;
   logic [XLEN-1:0] ex_mem_store_data;
   logic [4:0]      ex_mem_rd;
   logic            ex_mem_reg_write;
   logic            ex_mem_mem_read;
   logic            ex_mem_mem_write;

   ex_stage #(.XLEN(XLEN)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .id_ex_valid       (id_ex_valid),
      .id_ex_alu_op      (id_ex_alu_op),
      .id_ex_alu_src     (id_ex_alu_src),
      .id_ex_imm         (id_ex_imm),
      .id_ex_rs1_data    (id_ex_rs1_data),
      .id_ex_rs2_data    (id_ex_rs2_data),
      .id_ex_rd          (id_ex_rd),
      .id_ex_reg_write   (id_ex_reg_write),
      .id_ex_mem_read    (id_ex_mem_read),
      .id_ex_mem_write   (id_ex_mem_write),
      .forward_a         (forward_a),
      .forward_b         (forward_b),
      .ex_mem_fwd_data   (ex_mem_fwd_data),
      .mem_wb_fwd_data   (mem_wb_fwd_data),
      .flush             (flush),
      .ex_stall          (ex_stall),
      .ex_mem_valid      (ex_mem_valid),
      .ex_mem_alu_result (ex_mem_alu_result),
      .ex_mem_store_data (ex_mem_store_data),
      .ex_mem_rd         (ex_mem_rd),
      .ex_mem_reg_write  (ex_mem_reg_write),
      .ex_mem_mem_read   (ex_mem_mem_read),
      .ex_mem_mem_write  (ex_mem_mem_write)
   );

   always #5 clk = ~clk;

   int n_vec        = 0;
   int n_err        = 0;
   int stall_cycles = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                        input logic [31:0] exm, input logic [31:0] mwb);
      if (sel == 2'b10) return exm;
      if (sel == 2'b01) return mwb;
      return rf;
   endfunction

   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic signed [31:0] sa, sb;
      int sh;
      sa = a;
      sb = b;
      sh = int'(b % 32);
      case (op)
         4'd0:    return a + b;
         4'd1:    return a - b;
         4'd2:    return a & b;
         4'd3:    return a | b;
         4'd4:    return a ^ b;
         4'd5:    return a << sh;
         4'd6:    return a >> sh;
         4'd7:    return sa >>> sh;
         4'd8:    return (sa < sb) ? 32'd1 : 32'd0;
         4'd9:    return (a < b) ? 32'd1 : 32'd0;
         4'd11:   return b;
         default: return 32'd0;
      endcase
   endfunction

   // Expected EX/MEM contents and MUL bookkeeping.
   logic        m_valid, m_rw, m_mr, m_mw, m_busy, m_mrw;
   logic [31:0] m_res, m_sd, m_prod;
   logic [4:0]  m_rd, m_mrd;
   int          m_left;

   always @(negedge clk) begin : compare
      logic [31:0] a, b, fb;
      logic        exp_stall;
      if (!rst_n) begin
         m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_busy = 0; m_mrw = 0;
         m_res = 0; m_sd = 0; m_prod = 0; m_rd = 0; m_mrd = 0; m_left = 0;
         check("rst_valid",  32'(ex_mem_valid), 32'd0);
         check("rst_result", ex_mem_alu_result, 32'd0);
         check("rst_store",  ex_mem_store_data, 32'd0);
         check("rst_rd",     32'(ex_mem_rd), 32'd0);
         check("rst_ctrl",   32'({ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write}), 32'd0);
         check("rst_stall",  32'(ex_stall), 32'd0);
      end else begin
         check("valid",      32'(ex_mem_valid), 32'(m_valid));
         check("alu_result", ex_mem_alu_result, m_res);
         check("store_data", ex_mem_store_data, m_sd);
         check("rd",         32'(ex_mem_rd), 32'(m_rd));
         check("reg_write",  32'(ex_mem_reg_write), 32'(m_rw));
         check("mem_read",   32'(ex_mem_mem_read), 32'(m_mr));
         check("mem_write",  32'(ex_mem_mem_write), 32'(m_mw));

         a  = pick(forward_a, id_ex_rs1_data, ex_mem_fwd_data, mem_wb_fwd_data);
         fb = pick(forward_b, id_ex_rs2_data, ex_mem_fwd_data, mem_wb_fwd_data);
         b  = id_ex_alu_src ? id_ex_imm : fb;

         if (m_busy) exp_stall = !flush && (m_left > 1);
         else        exp_stall = id_ex_valid && (id_ex_alu_op == 4'd10) && !flush;
         check("ex_stall", 32'(ex_stall), 32'(exp_stall));
         if (ex_stall) stall_cycles++;

         // Next EX/MEM state; every bubble clears the control bits.
         if (m_busy) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
            if (flush) begin
               m_busy = 0;
            end else if (m_left == 1) begin
               m_busy = 0; m_valid = 1; m_res = m_prod; m_rd = m_mrd; m_rw = m_mrw;
            end else begin
               m_left--;
            end
         end else if (flush || id_ex_alu_op == 4'd10) begin
            m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0;
            if (!flush && id_ex_valid) begin
               m_busy = 1; m_left = XLEN; m_prod = a * b;
               m_mrd = id_ex_rd; m_mrw = id_ex_reg_write;
            end
         end else begin
            m_valid = id_ex_valid; m_res = ref_alu(id_ex_alu_op, a, b); m_sd = fb;
            m_rd = id_ex_rd; m_rw = id_ex_reg_write; m_mr = id_ex_mem_read; m_mw = id_ex_mem_write;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      id_ex_valid = 0; id_ex_alu_op = 0; id_ex_alu_src = 0; id_ex_imm = 0;
      id_ex_rs1_data = 0; id_ex_rs2_data = 0; id_ex_rd = 0; id_ex_reg_write = 0;
      id_ex_mem_read = 0; id_ex_mem_write = 0; forward_a = 0; forward_b = 0;
      ex_mem_fwd_data = 0; mem_wb_fwd_data = 0; flush = 0;
   endtask

   function automatic logic [31:0] rand_word();
      case ($urandom_range(3))
         0:       return 32'($urandom_range(40));
         1:       return 32'hFFFF_FFFF - 32'($urandom_range(40));
         default: return $urandom;
      endcase
   endfunction

   task automatic rand_inputs();
      id_ex_valid     = ($urandom_range(7) != 0);
      id_ex_alu_op    = ($urandom_range(9) == 0) ? 4'd10 : 4'($urandom_range(15));
      id_ex_alu_src   = 1'($urandom_range(1));
      id_ex_imm       = rand_word();
      id_ex_rs1_data  = rand_word();
      id_ex_rs2_data  = rand_word();
      ex_mem_fwd_data = rand_word();
      mem_wb_fwd_data = rand_word();
      forward_a       = 2'($urandom_range(3));
      forward_b       = 2'($urandom_range(3));
      id_ex_rd        = 5'($urandom_range(31));
      id_ex_reg_write = id_ex_valid & 1'($urandom_range(1));
      id_ex_mem_read  = id_ex_valid & 1'($urandom_range(1));
      id_ex_mem_write = id_ex_valid & 1'($urandom_range(1));
      flush           = ($urandom_range(19) == 0);
   endtask

   // Waits (bounded) for ex_mem_valid, scrambling forwarding data meanwhile.
   task automatic wait_result(input string name, output int n);
      logic done;
      done = 0;
      n    = 0;
      for (int i = 0; i < 40 && !done; i++) begin
         cyc();
         n++;
         if (ex_mem_valid) done = 1;
         else begin
            ex_mem_fwd_data = $urandom;
            mem_wb_fwd_data = $urandom;
         end
      end
      if (!done) check(name, 32'd0, 32'd1);
   endtask

   int n_wait;

   initial begin
      rst_n = 0;
      idle_inputs();
      #1;
      check("reset_result", ex_mem_alu_result, 32'd0);
      check("reset_stall",  32'(ex_stall), 32'd0);
      repeat (2) cyc();
      rst_n = 1;

      // ADD with EX/MEM forwarding on A: 5 + 7
      id_ex_valid = 1; id_ex_alu_op = 4'd0; forward_a = 2'b10; ex_mem_fwd_data = 5;
      id_ex_rs2_data = 7; id_ex_rd = 5'd3; id_ex_reg_write = 1;
      cyc();
      check("add_fwd", ex_mem_alu_result, 32'd12);
      check("add_valid", 32'(ex_mem_valid), 32'd1);

      idle_inputs(); id_ex_valid = 1; id_ex_alu_op = 4'd1; id_ex_rs2_data = 1;
      cyc();
      check("sub_wrap", ex_mem_alu_result, 32'hFFFF_FFFF);

      idle_inputs(); id_ex_valid = 1; id_ex_alu_op = 4'd7; id_ex_rs1_data = 32'h8000_0000;
      id_ex_imm = 31; id_ex_alu_src = 1;
      cyc();
      check("sra_imm", ex_mem_alu_result, 32'hFFFF_FFFF);

      idle_inputs(); id_ex_valid = 1; id_ex_alu_op = 4'd9; id_ex_rs1_data = 1;
      id_ex_rs2_data = 32'hFFFF_FFFF;
      cyc();
      check("sltu", ex_mem_alu_result, 32'd1);

      // Store: address from A+imm, data forwarded from EX/MEM.
      idle_inputs(); id_ex_valid = 1; id_ex_alu_op = 4'd0; id_ex_rs1_data = 32'h100;
      id_ex_imm = 32'h20; id_ex_alu_src = 1; forward_b = 2'b10; ex_mem_fwd_data = 32'hDEAD;
      id_ex_mem_write = 1;
      cyc();
      check("store_data", ex_mem_store_data, 32'hDEAD);
      check("store_we",   32'(ex_mem_mem_write), 32'd1);
      check("store_addr", ex_mem_alu_result, 32'h120);

      // MUL 0xFFFFFFFF * 3 with B from MEM/WB.
      idle_inputs(); id_ex_valid = 1; id_ex_alu_op = 4'd10; id_ex_rs1_data = 32'hFFFF_FFFF;
      forward_b = 2'b01; mem_wb_fwd_data = 3; id_ex_rd = 5'd9; id_ex_reg_write = 1;
      #1;
      check("mul_accept_stall", 32'(ex_stall), 32'd1);
      stall_cycles = 0;
      cyc();
      idle_inputs();
      wait_result("mul_timeout", n_wait);
      check("mul_latency", 32'(n_wait), 32'd32);
      check("mul_stall_cycles", 32'(stall_cycles), 32'd32);
      check("mul_result", ex_mem_alu_result, 32'hFFFF_FFFD);
      check("mul_rd", 32'(ex_mem_rd), 32'd9);

      // MUL aborted by flush at busy count 10.
      idle_inputs(); id_ex_valid = 1; id_ex_alu_op = 4'd10; id_ex_rs1_data = 1234;
      id_ex_rs2_data = 5678; id_ex_rd = 5'd4; id_ex_reg_write = 1;
      cyc();
      idle_inputs();
      repeat (10) cyc();
      flush = 1;
      #1;
      check("flush_stall", 32'(ex_stall), 32'd0);
      cyc();
      check("flush_bubble", 32'(ex_mem_valid), 32'd0);
      check("flush_hold", ex_mem_alu_result, 32'hFFFF_FFFD);
      idle_inputs(); id_ex_valid = 1; id_ex_rs1_data = 2; id_ex_rs2_data = 3;
      #1;
      check("post_flush_stall", 32'(ex_stall), 32'd0);
      cyc();
      check("post_flush_add", ex_mem_alu_result, 32'd5);

      // Reset pulse at busy count 5.
      idle_inputs(); id_ex_valid = 1; id_ex_alu_op = 4'd10; id_ex_rs1_data = 77;
      id_ex_rs2_data = 9; id_ex_rd = 5'd7; id_ex_reg_write = 1;
      cyc();
      idle_inputs();
      repeat (5) cyc();
      rst_n = 0;
      #1;
      check("midmul_rst_result", ex_mem_alu_result, 32'd0);
      check("midmul_rst_rd", 32'(ex_mem_rd), 32'd0);
      check("midmul_rst_stall", 32'(ex_stall), 32'd0);
      cyc();
      rst_n = 1;
      id_ex_valid = 1; id_ex_alu_op = 4'd4; id_ex_rs1_data = 32'hF0; id_ex_rs2_data = 32'hFF;
      cyc();
      check("post_rst_xor", ex_mem_alu_result, 32'h0F);
      check("post_rst_valid", 32'(ex_mem_valid), 32'd1);

      // Back-to-back MUL held in ID/EX: second one accepted right after.
      idle_inputs(); id_ex_valid = 1; id_ex_alu_op = 4'd10; id_ex_rs1_data = 7;
      id_ex_rs2_data = 6; id_ex_rd = 5'd12; id_ex_reg_write = 1;
      cyc();
      wait_result("b2b1_timeout", n_wait);
      check("b2b1_result", ex_mem_alu_result, 32'd42);
      check("b2b2_accept_stall", 32'(ex_stall), 32'd1);
      cyc();
      wait_result("b2b2_timeout", n_wait);
      check("b2b2_result", ex_mem_alu_result, 32'd42);
      idle_inputs();
      cyc();

      // Randomized traffic, checked by the compare process.
      for (int i = 0; i < 1500; i++) begin
         rand_inputs();
         cyc();
      end
      idle_inputs();
      repeat (3) cyc();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage pipeline. It sits between the ID/EX register and the EX/MEM register.
- It consumes the ForwardA/ForwardB selects from the forwarding unit and resolves operands from the register file, EX/MEM or MEM/WB.
- Single-cycle ALU ops complete in one cycle. MUL uses an iterative shift-add multiplier that stalls the front end.
- The block owns the EX/MEM pipeline register.

Parameters:
XLEN, 32, datapath width
SHAMT_W, $clog2(XLEN), shift-amount width (derived; not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_ex_valid  in  1  ID/EX holds a real instruction
id_ex_alu_op  in  4  operation code
id_ex_alu_src  in  1  1: operand B = immediate
id_ex_imm  in  XLEN  sign-extended immediate
id_ex_rs1_data  in  XLEN  register-file rs1 value
id_ex_rs2_data  in  XLEN  register-file rs2 value
id_ex_rd  in  5  destination register
id_ex_reg_write  in  1  writeback enable
id_ex_mem_read  in  1  load
id_ex_mem_write  in  1  store
forward_a  in  2  00 regfile, 10 EX/MEM, 01 MEM/WB, 11 treated as 00
forward_b  in  2  same encoding, operand B / store data
ex_mem_fwd_data  in  XLEN  EX/MEM result for forwarding
mem_wb_fwd_data  in  XLEN  MEM/WB writeback value for forwarding
flush  in  1  synchronous squash of the EX instruction
ex_stall  out  1  hold PC, IF/ID, ID/EX
ex_mem_valid  out  1  registered
ex_mem_alu_result  out  XLEN  registered
ex_mem_store_data  out  XLEN  registered, forwarded rs2
ex_mem_rd  out  5  registered
ex_mem_reg_write  out  1  registered
ex_mem_mem_read  out  1  registered
ex_mem_mem_write  out  1  registered

Behaviour:
- Reset (rst_n=0, asynchronous): all ex_mem_* outputs are 0, FSM is IDLE, counter and multiplier regs are 0, ex_stall=0.
- Operand A = mux(forward_a). Operand B = id_ex_alu_src ? id_ex_imm : mux(forward_b). Store data = mux(forward_b) regardless of alu_src.
- ALU op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; the shift amount is B[SHAMT_W-1:0].
  - 8 SLT (signed), 9 SLTU: result is 1 or 0, zero-extended.
  - 10 MUL: low XLEN bits of A*B.
  - 11 PASSB.
  - 12-15: result 0.
- All arithmetic wraps modulo 2^XLEN.
- FSM states: IDLE, MUL_BUSY.
- IDLE, non-MUL (or id_ex_valid=0): on the next edge EX/MEM loads the result and the control fields. ex_mem_valid takes id_ex_valid. Latency is 1 cycle and ex_stall=0.
- IDLE, id_ex_valid=1, op=MUL, flush=0 (accept cycle):
  - ex_stall=1 combinationally.
  - On the edge, latch mcand=A, mplier=B (the forwarded values; EX/MEM and MEM/WB forwarding sources are not used after this edge), and latch rd and reg_write.
  - Also on the edge: product=0, count=0, go to MUL_BUSY, and load EX/MEM with a bubble.
- MUL_BUSY, each edge:
  - if mplier[0], product += mcand; then mcand <<= 1, mplier >>= 1, count++.
  - id_ex_* and forward_* inputs are ignored in this state.
- MUL_BUSY, count < XLEN-1: ex_stall=1 and EX/MEM loads a bubble.
- MUL_BUSY, count == XLEN-1:
  - ex_stall=0 combinationally.
  - On the edge, EX/MEM loads the final product (including this iteration) with valid=1 and the latched rd/reg_write; mem_read=mem_write=0.
  - FSM returns to IDLE. ID/EX advances on the same edge.
- Total ex_stall high time for a MUL is exactly XLEN cycles. The result is visible in EX/MEM XLEN+1 edges after the accept edge's cycle start.
- Bubble: ex_mem_valid, reg_write, mem_read and mem_write are 0. alu_result, store_data and rd hold their previous values.
- flush (highest priority):
  - IDLE: EX/MEM loads a bubble and no MUL is accepted.
  - MUL_BUSY: abort to IDLE and load a bubble. ex_stall=0 in that cycle (ex_stall = busy & ~flush). No result is written.
- Reset asserted mid-MUL: immediate return to IDLE with outputs 0 and no result.
- A MUL with id_ex_valid=0 is treated as a bubble and is not accepted.
- A back-to-back MUL in ID/EX at the completing edge is accepted on the following IDLE cycle.

Test Plan:
- ADD, forward_a=10, ex_mem_fwd_data=5, rs2=7, forward_b=00 -> next cycle ex_mem_alu_result=12, valid=1.
- SUB, A=0, B=1 -> 0xFFFFFFFF. SRA, A=0x80000000, imm=31, alu_src=1 -> 0xFFFFFFFF. SLTU, A=1, B=0xFFFFFFFF -> 1.
- MUL, A=0xFFFFFFFF, B=3, forward_b=01 (mem_wb_fwd_data=3):
  - ex_stall high exactly 32 cycles.
  - ex_mem_valid=0 throughout.
  - Then ex_mem_alu_result=0xFFFFFFFD with the latched rd.
  - Changing the forwarding data mid-op has no effect.
- MUL 1234*5678, flush asserted at busy count 10 -> ex_stall drops that cycle, EX/MEM bubble, FSM IDLE, next ADD completes in 1 cycle.
- rst_n pulsed low at busy count 5 -> all outputs 0 immediately. After release, a non-MUL instruction executes normally.
- Store with alu_src=1, forward_b=10, ex_mem_fwd_data=0xDEAD -> ex_mem_store_data=0xDEAD, ex_mem_mem_write=1, alu_result = A+imm.
